// File: rtl/expr_pkg.sv
// Shared constants for the expression string transmitter and its decoder-side helpers.
package expr_pkg;

   localparam int unsigned MAX_TERMS_DEF = 8;

   // One-hot FSM encoding
   typedef enum logic [3:0] {
      StIdle  = 4'b0001,
      StDigit = 4'b0010,
      StOp    = 4'b0100,
      StFin   = 4'b1000
   } state_e;

   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_DIV   = 8'h2F;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CH_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/op_char_enc.sv
// Maps a 2-bit operator code to its ASCII character.
module op_char_enc
   import expr_pkg::*;
(
   input  logic [1:0] i_code,
   output logic [7:0] o_char
);

   always_comb begin
      o_char = CH_PLUS;
      case (i_code)
         OP_ADD:  o_char = CH_PLUS;
         OP_SUB:  o_char = CH_MINUS;
         OP_MUL:  o_char = CH_MUL;
         OP_DIV:  o_char = CH_DIV;
         default: o_char = CH_PLUS;
      endcase
   end

endmodule

// File: rtl/expr_string_tx.sv
// Emits a latched batch of digits and operators as a byte-serial ASCII
// string D (O D)* over a valid/ready handshake.
module expr_string_tx
   import expr_pkg::*;
#(
   parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
   parameter int unsigned TW        = 4
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   i_start,
   input  logic [TW-1:0]          i_terms,
   input  logic [4*MAX_TERMS-1:0] i_digits,
   input  logic [2*MAX_TERMS-3:0] i_ops,
   input  logic                   i_ready,
   output logic [7:0]             o_out,
   output logic                   o_valid,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

   state_e                 r_state;
   logic [TW-1:0]          r_idx;
   logic [TW-1:0]          r_terms;
   logic [4*MAX_TERMS-1:0] r_digits;
   logic [2*MAX_TERMS-3:0] r_ops;
   logic [7:0]             r_out;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;

   logic                   w_load_ok;
   logic                   w_digits_ok;
   logic [1:0]             w_op_code;
   logic [7:0]             w_op_char;
   logic [3:0]             w_next_digit;
   logic                   w_last;
   logic                   w_xfer;

   // Only digits that will actually be sent are range-checked
   always_comb begin
      w_digits_ok = 1'b1;
      for (int unsigned i = 0; i < MAX_TERMS; i++) begin
         if ((TW'(i) < i_terms) && (i_digits[4*i +: 4] > 4'd9)) begin
            w_digits_ok = 1'b0;
         end
      end
      w_load_ok = (i_terms != '0) && (i_terms <= TW'(MAX_TERMS)) && w_digits_ok;
   end

   always_comb begin
      w_op_code    = 2'd0;
      w_next_digit = 4'd0;
      for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
         if (r_idx == TW'(i)) begin
            w_op_code    = r_ops[2*i +: 2];
            w_next_digit = r_digits[4*(i+1) +: 4];
         end
      end
   end

   assign w_last = (r_idx == (r_terms - TW'(1)));
   assign w_xfer = r_valid && i_ready;

   op_char_enc u_op_char_enc (
      .i_code (w_op_code),
      .o_char (w_op_char)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state  <= StIdle;
         r_idx    <= '0;
         r_terms  <= '0;
         r_digits <= '0;
         r_ops    <= '0;
         r_out    <= 8'h00;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (w_load_ok) begin
                     r_digits <= i_digits;
                     r_ops    <= i_ops;
                     r_terms  <= i_terms;
                     r_idx    <= '0;
                     r_busy   <= 1'b1;
                     r_valid  <= 1'b1;
                     r_out    <= digit_char(i_digits[3:0]);
                     r_state  <= StDigit;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            StDigit: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_out   <= 8'h00;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StFin;
                  end else begin
                     r_out   <= w_op_char;
                     r_state <= StOp;
                  end
               end
            end
            StOp: begin
               if (w_xfer) begin
                  r_idx   <= r_idx + TW'(1);
                  r_out   <= digit_char(w_next_digit);
                  r_state <= StDigit;
               end
            end
            StFin: begin
               // done was raised on entry; start is deliberately not sampled here
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
               r_idx   <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_out   <= 8'h00;
            end
         endcase
      end
   end

   assign o_out   = r_out;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_err   = r_err;

endmodule

// File: tb/tb_expr_string_tx.sv
// Self-checking bench for expr_string_tx: directed cases plus random loads
// compared against a string-building reference model and a recognizer model.
module tb_expr_string_tx;

   localparam int unsigned MT = 8;
   localparam int unsigned TW = 4;

   logic              clk = 1'b0;
   logic              clr;
   logic              i_start;
   logic [TW-1:0]     i_terms;
   logic [4*MT-1:0]   i_digits;
   logic [2*MT-3:0]   i_ops;
   logic              i_ready;
   logic [7:0]        o_out;
   logic              o_valid;
   logic              o_busy;
   logic              o_done;
   logic              o_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] oc [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};

   always #5 clk = ~clk;

   expr_string_tx #(
      .MAX_TERMS (MT),
      .TW        (TW)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .i_start  (i_start),
      .i_terms  (i_terms),
      .i_digits (i_digits),
      .i_ops    (i_ops),
      .i_ready  (i_ready),
      .o_out    (o_out),
      .o_valid  (o_valid),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Recognizer: 0 empty, 1 after digit, 2 after operator, 3 rejected
   function automatic int rec_feed(input int st, input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return (st == 0 || st == 2) ? 1 : 3;
      if (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F) return (st == 1) ? 2 : 3;
      return 3;
   endfunction

   // rmode: 0 ready always high, 1 pattern 1,0,0 repeating, 2 random
   task automatic run_load(input int n, input logic [31:0] dig, input logic [13:0] opv,
                           input int rmode, input bit poke);
      logic [7:0] exp_q[$];
      int         cyc;
      int         got;
      int         rec;
      bit         done_seen;
      bit         prev_hold;
      logic [8:0] prev_vo;
      logic       rdy;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(8'h30 + 8'(dig[4*i +: 4]));
         if (i < n - 1) exp_q.push_back(oc[opv[2*i +: 2]]);
      end
      i_terms  = TW'(n);
      i_digits = dig;
      i_ops    = opv;
      i_start  = 1'b1;
      step();
      i_start = 1'b0;
      chk("first_valid", 32'(o_valid), 32'd1);
      cyc       = 0;
      got       = 0;
      rec       = 0;
      done_seen = 1'b0;
      prev_hold = 1'b0;
      prev_vo   = '0;
      while (cyc < 400) begin
         if (prev_hold) chk("hold_stable", 32'({o_valid, o_out}), 32'(prev_vo));
         if (o_done) begin
            done_seen = 1'b1;
            break;
         end
         chk("busy_during", 32'(o_busy), 32'd1);
         chk("no_err_busy", 32'(o_err), 32'd0);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom);
         endcase
         i_ready = rdy;
         if (poke) i_start = 1'($urandom);
         if (o_valid && rdy) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 32'(o_out), 32'hFFFF);
            end else begin
               chk("byte", 32'(o_out), 32'(exp_q.pop_front()));
            end
            rec = rec_feed(rec, o_out);
            got++;
         end
         prev_hold = o_valid && !rdy;
         prev_vo   = {o_valid, o_out};
         step();
         cyc++;
      end
      chk("done_seen", 32'(done_seen), 32'd1);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      chk("byte_count", 32'(got), 32'(2*n - 1));
      chk("recognizer_ok", 32'(rec), 32'd1);
      chk("fin_valid", 32'(o_valid), 32'd0);
      chk("fin_busy", 32'(o_busy), 32'd0);
      if (rmode == 0) chk("cycles", 32'(cyc), 32'(2*n - 1));
      // start during the done cycle must be ignored
      i_start = 1'b1;
      step();
      chk("done_pulse_len", 32'(o_done), 32'd0);
      chk("fin_start_ign", 32'(o_valid), 32'd0);
      i_start = 1'b0;
      step();
      chk("idle_after", 32'(o_valid), 32'd0);
   endtask

   task automatic try_bad(input int n, input logic [31:0] dig);
      i_terms  = TW'(n);
      i_digits = dig;
      i_ops    = '0;
      i_start  = 1'b1;
      step();
      i_start = 1'b0;
      chk("bad_err", 32'(o_err), 32'd1);
      chk("bad_valid", 32'(o_valid), 32'd0);
      chk("bad_busy", 32'(o_busy), 32'd0);
      step();
      chk("bad_err_pulse", 32'(o_err), 32'd0);
      chk("bad_valid2", 32'(o_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] dig;
      logic [13:0] opv;
      int          n;
      clr      = 1'b1;
      i_start  = 1'b0;
      i_terms  = '0;
      i_digits = '0;
      i_ops    = '0;
      i_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(o_out), 32'h00);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      clr = 1'b0;
      step();

      // digits {7,0,4}, ops {+,*}
      run_load(3, 32'h0000_0407, 14'h0008, 0, 1'b0);
      run_load(1, 32'h0000_0009, 14'h0000, 0, 1'b0);
      run_load(3, 32'h0000_0407, 14'h0008, 1, 1'b0);
      // unused digit out of range is don't-care
      run_load(2, 32'h0000_0C58, 14'h0003, 0, 1'b0);
      run_load(8, 32'h9876_5432, 14'h2D1B, 0, 1'b0);

      try_bad(0, 32'h0000_0123);
      try_bad(9, 32'h0000_0123);
      try_bad(3, 32'h0000_04C7);

      // clr mid-string after two bytes accepted
      i_terms  = TW'(4);
      i_digits = 32'h0000_5321;
      i_ops    = 14'h001B;
      i_ready  = 1'b1;
      i_start  = 1'b1;
      step();
      i_start = 1'b0;
      chk("clr_b0", 32'(o_out), 32'h31);
      step();
      chk("clr_b1", 32'(o_out), 32'h2F);
      step();
      chk("clr_b2", 32'(o_out), 32'h32);
      clr = 1'b1;
      #1;
      chk("clr_out", 32'(o_out), 32'h00);
      chk("clr_valid", 32'(o_valid), 32'd0);
      chk("clr_busy", 32'(o_busy), 32'd0);
      step();
      chk("clr_no_done", 32'(o_done), 32'd0);
      clr = 1'b0;
      step();
      run_load(4, 32'h0000_5321, 14'h001B, 0, 1'b0);

      for (int k = 0; k < 200; k++) begin
         n = int'($urandom_range(1, MT));
         for (int i = 0; i < int'(MT); i++) begin
            dig[4*i +: 4] = (i < n) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
         end
         opv = 14'($urandom);
         run_load(n, dig, opv, int'($urandom_range(0, 2)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
